// File: rtl/combo_pattern_det_if.sv
// Bus bundle for the programmable pattern detector.
// The master drives the sample/config side; the slave returns status.
interface combo_pattern_det_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);

   logic             en;
   logic             cfg_we;
   logic [WIDTH-1:0] cfg_pattern;
   logic [WIDTH-1:0] cfg_mask;
   logic             clr;
   logic [WIDTH-1:0] din;
   logic             match;
   logic             detect;
   logic             active;
   logic [CNT_W-1:0] count;
   logic             ovf;

   modport master (
      output en,
      output cfg_we,
      output cfg_pattern,
      output cfg_mask,
      output clr,
      output din,
      input  match,
      input  detect,
      input  active,
      input  count,
      input  ovf
   );

   modport slave (
      input  en,
      input  cfg_we,
      input  cfg_pattern,
      input  cfg_mask,
      input  clr,
      input  din,
      output match,
      output detect,
      output active,
      output count,
      output ovf
   );

endinterface

// File: rtl/combo_pattern_det.sv
// Masked pattern detector with hold qualification.
// A detection needs HOLD consecutive hits; detections are counted.
module combo_pattern_det #(
   parameter int               WIDTH           = 4,
   parameter int               HOLD            = 2,
   parameter int               CNT_W           = 8,
   parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(4'b0110)
) (
   input logic                clk,
   input logic                rst,
   combo_pattern_det_if.slave bus
);

   localparam int RUN_W = $clog2(HOLD + 1);

   localparam logic [RUN_W-1:0] HOLD_R  = RUN_W'(HOLD);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LOCK
   } state_t;

   logic [WIDTH-1:0] pattern_q;
   logic [WIDTH-1:0] mask_q;
   state_t           state_q;
   logic [RUN_W-1:0] run_q;
   logic             match_q;
   logic             detect_q;
   logic             active_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;

   logic             hit;
   logic             lock_entry;

   // A config write edge never counts as a hit; held pattern/mask only.
   assign hit = bus.en
              & ~bus.cfg_we
              & (((bus.din ^ pattern_q) & mask_q) == '0);

   // Flags the edge on which the FSM moves into LOCK.
   always_comb begin
      lock_entry = 1'b0;
      unique case (state_q)
         IDLE:    lock_entry = hit && (HOLD == 1);
         RUN:     lock_entry = hit && ((run_q + RUN_ONE) == HOLD_R);
         default: lock_entry = 1'b0;
      endcase
   end

   // Pattern and care-mask registers, loaded by a config write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= DEFAULT_PATTERN;
         mask_q    <= '1;
      end else if (bus.cfg_we) begin
         pattern_q <= bus.cfg_pattern;
         mask_q    <= bus.cfg_mask;
      end
   end

   // Hold-qualification FSM with registered match/detect/active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         run_q    <= '0;
         match_q  <= 1'b0;
         detect_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         match_q  <= hit;
         detect_q <= lock_entry;
         active_q <= lock_entry | ((state_q == LOCK) & hit);
         unique case (state_q)
            IDLE: begin
               if (hit) begin
                  if (HOLD == 1) begin
                     state_q <= LOCK;
                     run_q   <= HOLD_R;
                  end else begin
                     state_q <= RUN;
                     run_q   <= RUN_ONE;
                  end
               end
            end
            RUN: begin
               if (!hit) begin
                  state_q <= IDLE;
                  run_q   <= '0;
               end else if (lock_entry) begin
                  state_q <= LOCK;
                  run_q   <= HOLD_R;
               end else begin
                  run_q   <= run_q + RUN_ONE;
               end
            end
            LOCK: begin
               if (!hit) begin
                  state_q <= IDLE;
                  run_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               run_q   <= '0;
            end
         endcase
      end
   end

   // Saturating detection counter; clear wins but keeps a same-edge hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         count_q <= lock_entry ? CNT_ONE : '0;
         ovf_q   <= 1'b0;
      end else if (lock_entry) begin
         if (count_q == CNT_MAX) begin
            ovf_q   <= 1'b1;
         end else begin
            count_q <= count_q + CNT_ONE;
         end
      end
   end

   assign bus.match  = match_q;
   assign bus.detect = detect_q;
   assign bus.active = active_q;
   assign bus.count  = count_q;
   assign bus.ovf    = ovf_q;

endmodule
